// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one unified memory port between the Fetch stage (instruction reads)
// and the Writeback load/store unit. One access is outstanding at a time: the
// winning command is latched into the mem_* registers on the IDLE edge, the
// memory handshake is held until mem_ready, and the read data is returned with
// a one-cycle valid pulse to the requester that won.
//
// Optional feature (compile-time macro ARB_STARVE_GUARD_EN): a starvation guard
// that forces a fetch grant after STARVE_MAX consecutive data grants while
// Fetch is waiting. Without the macro, data has strict priority.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   if_req/if_addr/if_kill     fetch request, address, misprediction kill
//   if_valid/if_rdata/if_stall fetch data pulse, instruction word, stall
//   d_req/d_we/d_be/d_addr/d_wdata  data request command
//   d_valid/d_rdata/d_stall    data completion pulse, load data, stall
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  registered memory command
//   mem_ready/mem_rdata        memory completion and read data

module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,
    // Fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_stall,
    // Data port
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_valid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_stall,
    // Memory port
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StFetch, StData, StDrain} state_e;

    state_e            r_state;
    state_e            w_state_d;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [DW/8-1:0]   r_mem_be;
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;

    logic              r_if_valid;
    logic [DW-1:0]     r_if_rdata;
    logic              r_d_valid;
    logic [DW-1:0]     r_d_rdata;

    logic              w_arb_en;
    logic              w_f_ok;
    logic              w_force;
    logic              w_grant_f;
    logic              w_grant_d;
    logic              w_if_done;
    logic              w_d_done;
    logic              w_mem_done;

    // A requester still holds its request during its own valid pulse; no grant
    // is made in a pulse cycle so that stale request is never served twice.
    assign w_arb_en = ~r_if_valid & ~r_d_valid;
    // A fetch killed in the same cycle is never granted.
    assign w_f_ok   = if_req & ~if_kill;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_cnt_d;

    assign w_force = (r_starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        w_starve_cnt_d = r_starve_cnt;
        if (!if_req || w_grant_f) begin
            w_starve_cnt_d = 4'd0;
        end else if (w_grant_d && (r_starve_cnt != 4'hF)) begin
            w_starve_cnt_d = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_starve_cnt_d;
        end
    end
`else
    // Strict data priority; STARVE_MAX only matters with the guard compiled in.
    logic w_unused_starve_max;
    assign w_unused_starve_max = ^STARVE_MAX;
    assign w_force             = 1'b0;
`endif

    // Next-state and grant decode.
    always_comb begin
        w_state_d = r_state;
        w_grant_f = 1'b0;
        w_grant_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_arb_en) begin
                    if (w_f_ok && (!d_req || w_force)) begin
                        w_grant_f = 1'b1;
                        w_state_d = StFetch;
                    end else if (d_req) begin
                        w_grant_d = 1'b1;
                        w_state_d = StData;
                    end
                end
            end
            StFetch: begin
                // Completion wins over a same-cycle kill; the data is dropped below.
                if (mem_ready) begin
                    w_state_d = StIdle;
                end else if (if_kill) begin
                    w_state_d = StDrain;
                end
            end
            StData, StDrain: begin
                if (mem_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_mem_done = (r_state != StIdle) & mem_ready;
    assign w_if_done  = (r_state == StFetch) & mem_ready & ~if_kill;
    assign w_d_done   = (r_state == StData) & mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_valid   <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_d;

            if (w_grant_f) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= '1;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else if (w_grant_d) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
            end else if (w_mem_done) begin
                r_mem_req   <= 1'b0;
            end

            r_if_valid <= w_if_done;
            r_d_valid  <= w_d_done;

            if (w_if_done) begin
                r_if_rdata <= mem_rdata;
            end
            // Stores leave the load data register untouched.
            if (w_d_done && !r_mem_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    assign if_valid  = r_if_valid;
    assign if_rdata  = r_if_rdata;
    assign d_valid   = r_d_valid;
    assign d_rdata   = r_d_rdata;

    assign if_stall  = if_req & ~r_if_valid;
    assign d_stall   = d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table-driven per-cycle vectors for the basic
// fetch, arbitration and store sequences, then hand-written sequences for kill,
// starvation and reset-mid-access behaviour.

module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .AW(32),
        .DW(32),
        .STARVE_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_kill(if_kill),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .if_stall(if_stall),
        .d_req(d_req),
        .d_we(d_we),
        .d_be(d_be),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_valid(d_valid),
        .d_rdata(d_rdata),
        .d_stall(d_stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_be(mem_be),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic        ik;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [3:0]  db;
        logic [31:0] da;
        logic [31:0] dd;
        logic        mr;
        logic [31:0] md;
        logic        e_mreq;
        logic        e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
        logic        e_iv;
        logic [31:0] e_ird;
        logic        e_dv;
        logic [31:0] e_drd;
        logic        e_is;
        logic        e_ds;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        if_req    = 1'b0;
        if_addr   = 32'h0;
        if_kill   = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_be      = 4'h0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    int nd;
    int nf;
    int nd_at_fetch;

    initial begin
        // Row: inputs {ir,ik,ia,dr,dw,db,da,dd,mr,md},
        //      expected {mreq,mwe,mbe,maddr,mwdata,iv,ird,dv,drd,is,ds}
        // Zero-wait fetch of 0x100.
        vecs[0]  = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                     1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF,
                     1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        // Simultaneous fetch 0x104 and load 0x2000: data first, then fetch.
        vecs[4]  = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b1, 32'hCAFEF00D,
                     1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'h104, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h11111111,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h11111111,
                     1'b1, 1'b0, 4'hF, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h11111111,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h11111111, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        // Store 0x1234 to 0x3000, be=0x3, three wait states.
        vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b0, 32'h0,
                     1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        vecs[13] = vecs[12];
        vecs[14] = vecs[12];
        vecs[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b1, 32'hBAD0BAD0,
                     1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        // Store completion pulses once and keeps the previous load data.
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h3000, 32'h1234, 1'b1, 32'hBAD0BAD0,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};

        // ---------------- reset values ----------------
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst d_valid", {31'b0, d_valid}, 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        reset = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if_req    = vecs[i].ir;
            if_kill   = vecs[i].ik;
            if_addr   = vecs[i].ia;
            d_req     = vecs[i].dr;
            d_we      = vecs[i].dw;
            d_be      = vecs[i].db;
            d_addr    = vecs[i].da;
            d_wdata   = vecs[i].dd;
            mem_ready = vecs[i].mr;
            mem_rdata = vecs[i].md;
            #1;
            chk($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].e_mreq});
            chk($sformatf("v%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_iv});
            chk($sformatf("v%0d d_valid", i), {31'b0, d_valid}, {31'b0, vecs[i].e_dv});
            chk($sformatf("v%0d if_stall", i), {31'b0, if_stall}, {31'b0, vecs[i].e_is});
            chk($sformatf("v%0d d_stall", i), {31'b0, d_stall}, {31'b0, vecs[i].e_ds});
            if (vecs[i].e_mreq) begin
                chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_mwe});
                chk($sformatf("v%0d mem_be", i), {28'b0, mem_be}, {28'b0, vecs[i].e_mbe});
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
            end
            if (vecs[i].e_iv) chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_ird);
            if (vecs[i].e_dv) chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drd);
        end

        // ---------------- kill in flight ----------------
        @(negedge clk);
        set_idle();
        if_req  = 1'b1;
        if_addr = 32'h200;
        @(negedge clk);                      // FETCH
        #1;
        chk("kill c1 mem_req", {31'b0, mem_req}, 32'h1);
        chk("kill c1 mem_addr", mem_addr, 32'h200);
        if_kill = 1'b1;
        @(negedge clk);                      // DRAIN, first wait done
        if_kill = 1'b0;
        if_req  = 1'b0;
        #1;
        chk("kill c2 mem_req", {31'b0, mem_req}, 32'h1);
        @(negedge clk);                      // DRAIN, memory completes
        mem_ready = 1'b1;
        mem_rdata = 32'h99999999;
        #1;
        chk("kill c3 mem_req", {31'b0, mem_req}, 32'h1);
        chk("kill c3 if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);                      // IDLE, new load requested
        d_req     = 1'b1;
        d_addr    = 32'h4000;
        d_be      = 4'hF;
        mem_rdata = 32'h55AA55AA;
        #1;
        chk("kill c4 mem_req", {31'b0, mem_req}, 32'h0);
        chk("kill c4 if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("kill c5 mem_req", {31'b0, mem_req}, 32'h1);
        chk("kill c5 mem_addr", mem_addr, 32'h4000);
        chk("kill c5 if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        #1;
        chk("kill c6 d_valid", {31'b0, d_valid}, 32'h1);
        chk("kill c6 d_rdata", d_rdata, 32'h55AA55AA);
        chk("kill c6 if_valid", {31'b0, if_valid}, 32'h0);
        @(negedge clk);
        d_req = 1'b0;
        #1;
        chk("kill c7 d_valid", {31'b0, d_valid}, 32'h0);

        // ---------------- starvation ----------------
        @(negedge clk);
        set_idle();
        if_req    = 1'b1;
        if_addr   = 32'h300;
        d_req     = 1'b1;
        d_addr    = 32'h5000;
        d_be      = 4'hF;
        mem_ready = 1'b1;
        nd = 0;
        nf = 0;
        nd_at_fetch = -1;
        for (int c = 0; c < 80 && nf == 0; c++) begin
            @(negedge clk);
            #1;
            if (d_valid) nd++;
            if (if_valid) begin
                nf++;
                nd_at_fetch = nd;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve fetch granted", {31'b0, nf > 0}, 32'h1);
        chk("starve data before fetch", nd_at_fetch, 32'd4);
`else
        chk("starve fetch count", nf, 32'd0);
        chk("starve data >= 20", {31'b0, nd >= 20}, 32'h1);
`endif
        @(negedge clk);
        set_idle();
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- reset mid-DATA ----------------
        set_idle();
        d_req  = 1'b1;
        d_addr = 32'h6000;
        d_be   = 4'hF;
        @(negedge clk);                      // DATA, memory stalled
        #1;
        chk("rstmid mem_req before", {31'b0, mem_req}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid mem_req async", {31'b0, mem_req}, 32'h0);
        chk("rstmid d_valid async", {31'b0, d_valid}, 32'h0);
        @(negedge clk);
        d_req     = 1'b0;
        mem_ready = 1'b1;
        reset     = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rstmid c%0d d_valid", c), {31'b0, d_valid}, 32'h0);
            chk($sformatf("rstmid c%0d mem_req", c), {31'b0, mem_req}, 32'h0);
        end
        if_req    = 1'b1;
        if_addr   = 32'h700;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        #1;
        chk("rstmid fetch mem_req", {31'b0, mem_req}, 32'h1);
        chk("rstmid fetch mem_addr", mem_addr, 32'h700);
        @(negedge clk);
        #1;
        chk("rstmid fetch if_valid", {31'b0, if_valid}, 32'h1);
        chk("rstmid fetch if_rdata", if_rdata, 32'h77777777);
        chk("rstmid fetch d_valid", {31'b0, d_valid}, 32'h0);
        if_req = 1'b0;

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
